// File: rtl/decoder3x8_pulse.sv
// ---------------------------------------------------------------------------
// decoder3x8_pulse : 3-to-8 decoder driving a timed one-hot strobe with handshake
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decoder3x8_pulse #(
  parameter int PULSE_LEN = 1,
  parameter int GAP_LEN   = 0,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       done,
  output logic [7:0] accept_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Counters are loaded with length-1 so a zero count marks the final cycle.
  localparam logic [CNT_W-1:0] C_PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] C_GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_ZERO   = '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [7:0]       out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic [7:0]       accept_cnt_q, accept_cnt_d;

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    done_d       = 1'b0;
    accept_cnt_d = accept_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          out_d        = 8'b0000_0001 << in;
          out_valid_d  = 1'b1;
          counter_d    = C_PULSE_LOAD;
          accept_cnt_d = accept_cnt_q + 8'd1;
          state_d      = DRIVE;
        end
      end
      DRIVE: begin
        if (counter_q != C_CNT_ZERO) begin
          counter_d = counter_q - C_CNT_ONE;
        end else begin
          out_d       = 8'h00;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          if (GAP_LEN > 0) begin
            counter_d = C_GAP_LOAD;
            state_d   = GAP;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      GAP: begin
        if (counter_q != C_CNT_ZERO) begin
          counter_d = counter_q - C_CNT_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_d       = 8'h00;
        out_valid_d = 1'b0;
        counter_d   = C_CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      counter_q    <= C_CNT_ZERO;
      out_q        <= 8'h00;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      accept_cnt_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      accept_cnt_q <= accept_cnt_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign accept_cnt = accept_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder3x8_pulse.sv
// ---------------------------------------------------------------------------
// tb_decoder3x8_pulse : directed, table-driven bench for decoder3x8_pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_decoder3x8_pulse;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // a: PULSE_LEN=1/GAP_LEN=0, b: PULSE_LEN=3/GAP_LEN=2, c: PULSE_LEN=4/GAP_LEN=0
  logic [2:0] a_in, b_in, c_in;
  logic       a_valid, b_valid, c_valid;
  logic       a_ready, b_ready, c_ready;
  logic [7:0] a_out, b_out, c_out;
  logic       a_ov, b_ov, c_ov;
  logic       a_done, b_done, c_done;
  logic [7:0] a_cnt, b_cnt, c_cnt;

  decoder3x8_pulse u_a (
    .clk(clk), .rst_n(rst_n), .in(a_in), .in_valid(a_valid), .in_ready(a_ready),
    .out(a_out), .out_valid(a_ov), .done(a_done), .accept_cnt(a_cnt)
  );

  decoder3x8_pulse #(.PULSE_LEN(3), .GAP_LEN(2), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in(b_in), .in_valid(b_valid), .in_ready(b_ready),
    .out(b_out), .out_valid(b_ov), .done(b_done), .accept_cnt(b_cnt)
  );

  decoder3x8_pulse #(.PULSE_LEN(4), .GAP_LEN(0), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in(c_in), .in_valid(c_valid), .in_ready(c_ready),
    .out(c_out), .out_valid(c_ov), .done(c_done), .accept_cnt(c_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic       valid;
    logic [2:0] code;
    logic [7:0] exp_out;
    logic       exp_done;
    logic       exp_ready;
  } vec_t;

  vec_t sweep [16];

  initial begin
    // Each row: inputs applied now, outputs expected just after the next edge.
    sweep[0]  = '{1'b1, 3'd0, 8'h01, 1'b0, 1'b0};
    sweep[1]  = '{1'b1, 3'd0, 8'h00, 1'b1, 1'b1};
    sweep[2]  = '{1'b1, 3'd1, 8'h02, 1'b0, 1'b0};
    sweep[3]  = '{1'b1, 3'd1, 8'h00, 1'b1, 1'b1};
    sweep[4]  = '{1'b1, 3'd2, 8'h04, 1'b0, 1'b0};
    sweep[5]  = '{1'b1, 3'd2, 8'h00, 1'b1, 1'b1};
    sweep[6]  = '{1'b1, 3'd3, 8'h08, 1'b0, 1'b0};
    sweep[7]  = '{1'b1, 3'd3, 8'h00, 1'b1, 1'b1};
    sweep[8]  = '{1'b1, 3'd4, 8'h10, 1'b0, 1'b0};
    sweep[9]  = '{1'b1, 3'd4, 8'h00, 1'b1, 1'b1};
    sweep[10] = '{1'b1, 3'd5, 8'h20, 1'b0, 1'b0};
    sweep[11] = '{1'b1, 3'd5, 8'h00, 1'b1, 1'b1};
    sweep[12] = '{1'b1, 3'd6, 8'h40, 1'b0, 1'b0};
    sweep[13] = '{1'b1, 3'd6, 8'h00, 1'b1, 1'b1};
    sweep[14] = '{1'b1, 3'd7, 8'h80, 1'b0, 1'b0};
    sweep[15] = '{1'b0, 3'd7, 8'h00, 1'b1, 1'b1};

    a_in = 3'd0; b_in = 3'd0; c_in = 3'd0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;

    // Reset state, held and after asynchronous release
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_out", a_out, 8'h00);
    chk("rst_ov", a_ov, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_cnt", a_cnt, 8'h00);
    chk("rst_ready", a_ready, 1'b1);
    #2 rst_n = 1'b1;
    #1;
    chk("rel_ready_a", a_ready, 1'b1);
    chk("rel_ready_b", b_ready, 1'b1);
    chk("rel_out_b", b_out, 8'h00);
    step();

    // Single-cycle pulse, code 3
    a_in = 3'd3; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    chk("p1_out", a_out, 8'h08);
    chk("p1_ov", a_ov, 1'b1);
    chk("p1_done0", a_done, 1'b0);
    chk("p1_cnt", a_cnt, 8'd1);
    chk("p1_ready0", a_ready, 1'b0);
    step();
    chk("p1_out_end", a_out, 8'h00);
    chk("p1_done1", a_done, 1'b1);
    chk("p1_ready1", a_ready, 1'b1);
    step();
    chk("p1_done_clr", a_done, 1'b0);

    // Three-cycle pulse with two-cycle gap; a second request arrives while busy
    b_in = 3'd7; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("p3_out", b_out, 8'h80);
      chk("p3_ov", b_ov, 1'b1);
      chk("p3_ready", b_ready, 1'b0);
      chk("p3_done", b_done, 1'b0);
      if (i == 0) begin
        b_in = 3'd0; b_valid = 1'b1;
      end
      step();
    end
    chk("p3_out_end", b_out, 8'h00);
    chk("p3_done_c4", b_done, 1'b1);
    chk("p3_gap1_ready", b_ready, 1'b0);
    chk("p3_cnt_busy", b_cnt, 8'd1);
    step();
    chk("p3_gap2_ready", b_ready, 1'b0);
    chk("p3_gap2_done", b_done, 1'b0);
    chk("p3_gap2_out", b_out, 8'h00);
    step();
    chk("p3_idle_ready", b_ready, 1'b1);
    chk("p3_idle_out", b_out, 8'h00);
    chk("p3_idle_cnt", b_cnt, 8'd1);
    step();
    b_valid = 1'b0;
    chk("p3_second_out", b_out, 8'h01);
    chk("p3_second_cnt", b_cnt, 8'd2);
    repeat (6) step();
    chk("p3_drained", b_ready, 1'b1);

    // Back-to-back sweep of all codes on the default instance
    do_reset();
    for (int i = 0; i < 16; i++) begin
      a_valid = sweep[i].valid;
      a_in    = sweep[i].code;
      step();
      chk($sformatf("sweep%0d_out", i), a_out, sweep[i].exp_out);
      chk($sformatf("sweep%0d_ov", i), a_ov, (sweep[i].exp_out != 8'h00));
      chk($sformatf("sweep%0d_done", i), a_done, sweep[i].exp_done);
      chk($sformatf("sweep%0d_ready", i), a_ready, sweep[i].exp_ready);
    end
    chk("sweep_cnt", a_cnt, 8'd8);

    // Reset asserted in the second DRIVE cycle of a 4-cycle pulse
    c_in = 3'd5; c_valid = 1'b1;
    step();
    c_valid = 1'b0;
    chk("c_drive1", c_out, 8'h20);
    chk("c_cnt", c_cnt, 8'd1);
    step();
    chk("c_drive2", c_out, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("c_async_out", c_out, 8'h00);
    chk("c_async_ov", c_ov, 1'b0);
    chk("c_async_cnt", c_cnt, 8'h00);
    chk("c_async_ready", c_ready, 1'b1);
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("c_no_done", c_done, 1'b0);
      chk("c_no_out", c_out, 8'h00);
    end

    // 256 back-to-back accepts wrap the counter
    do_reset();
    a_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a_in = 3'(i);
      step();
      step();
      if (i == 254) chk("wrap_255", a_cnt, 8'd255);
    end
    a_valid = 1'b0;
    chk("wrap_0", a_cnt, 8'd0);
    step();
    chk("wrap_idle_out", a_out, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
